// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receive FIFO bus bundle between UART receiver, host and buffer
//
// Purpose: groups the receiver-facing inputs, host read/clear controls and the
//          buffer status outputs so they travel as one port.
// Signals:
//   rx_data  [7:0]     received byte from the UART receiver
//   rx_done            receiver frame-complete level (Tick domain, asynchronous)
//   tick               16x baud oversampling pulse (asynchronous)
//   rd_en              host pop request
//   clr_ovf            host clear of the sticky overflow flag
//   rd_data  [7:0]     popped byte
//   empty / full       occupancy flags
//   count    [ADDR_W:0] occupancy 0..DEPTH
//   overflow           sticky: a byte was dropped
//   timeout            non-empty and the line has been idle long enough
// Modports: master = receiver/host side, slave = buffer.

interface uart_rx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]      rx_data;
  logic            rx_done;
  logic            tick;
  logic            rd_en;
  logic            clr_ovf;
  logic [7:0]      rd_data;
  logic            empty;
  logic            full;
  logic [ADDR_W:0] count;
  logic            overflow;
  logic            timeout;

  modport master (
    output rx_data, rx_done, tick, rd_en, clr_ovf,
    input  rd_data, empty, full, count, overflow, timeout
  );

  modport slave (
    input  rx_data, rx_done, tick, rd_en, clr_ovf,
    output rd_data, empty, full, count, overflow, timeout
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive byte FIFO with overflow and idle-line timeout
//
// Purpose: captures each completed UART frame into a DEPTH-entry FIFO, serves
//          bytes to the host through a one-cycle-latency read port, and reports
//          occupancy, sticky overflow and an idle-line timeout.
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous reset, active high
//   bus   uart_rx_fifo_if.slave (rx_data, rx_done, tick, rd_en, clr_ovf in;
//         rd_data, empty, full, count, overflow, timeout out)
// Parameters:
//   DEPTH          FIFO entries, power of 2, 2..256
//   ADDR_W         log2(DEPTH)
//   TIMEOUT_TICKS  tick strobes of line idle before timeout, 1..65535

module uart_rx_fifo #(
  parameter int DEPTH         = 16,
  parameter int ADDR_W        = 4,
  parameter int TIMEOUT_TICKS = 640
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_fifo_if.slave bus
);

  localparam logic [ADDR_W:0] PTR_ONE     = (ADDR_W+1)'(1);
  localparam logic [15:0]     TIMEOUT_VAL = 16'(TIMEOUT_TICKS);

  // ---------------------------------------------------------------------------
  // Input conditioning: two synchronizer flops plus one edge flop per signal.
  // Everything resets to 1 so a level already high at reset release is not
  // mistaken for a fresh rising edge.
  // ---------------------------------------------------------------------------
  logic done_s1, done_s2, done_q;
  logic tick_s1, tick_s2, tick_q;
  logic wr_stb;
  logic tick_stb;

  always_ff @(posedge clk) begin
    if (rst) begin
      done_s1 <= 1'b1;
      done_s2 <= 1'b1;
      done_q  <= 1'b1;
      tick_s1 <= 1'b1;
      tick_s2 <= 1'b1;
      tick_q  <= 1'b1;
    end else begin
      done_s1 <= bus.rx_done;
      done_s2 <= done_s1;
      done_q  <= done_s2;
      tick_s1 <= bus.tick;
      tick_s2 <= tick_s1;
      tick_q  <= tick_s2;
    end
  end

  assign wr_stb   = done_s2 & ~done_q;
  assign tick_stb = tick_s2 & ~tick_q;

  // ---------------------------------------------------------------------------
  // Storage and pointers. Pointers carry one extra wrap bit so full and empty
  // are distinguishable without a separate counter.
  // ---------------------------------------------------------------------------
  logic [7:0]      mem [DEPTH];
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [7:0]      rd_data_q;
  logic            overflow_q;
  logic [15:0]     idle_cnt;

  logic empty_i;
  logic full_i;
  logic rd_ok;
  logic wr_ok;
  logic wr_drop;

  assign empty_i = (wr_ptr == rd_ptr);
  assign full_i  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  // A pop on an empty FIFO is ignored, even when a write lands in the same
  // cycle: the new byte is not yet readable.
  assign rd_ok   = bus.rd_en & ~empty_i;
  // When full, a same-cycle pop frees the slot the write is about to use.
  assign wr_ok   = wr_stb & (~full_i | rd_ok);
  assign wr_drop = wr_stb & ~wr_ok;

  // Memory contents are don't-care after reset, so no reset term here.
  // On a full-FIFO write+read the read below still sees the old byte in this
  // slot because both are non-blocking updates on the same edge.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr[ADDR_W-1:0]] <= bus.rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_data_q  <= 8'h00;
      overflow_q <= 1'b0;
      idle_cnt   <= 16'd0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end

      if (rd_ok) begin
        rd_data_q <= mem[rd_ptr[ADDR_W-1:0]];
        rd_ptr    <= rd_ptr + PTR_ONE;
      end

      // Set beats clear so a drop coincident with a clear is never lost.
      if (wr_drop) begin
        overflow_q <= 1'b1;
      end else if (bus.clr_ovf) begin
        overflow_q <= 1'b0;
      end

      // Idle counter: restarts on every accepted byte, saturates at the limit.
      if (wr_ok) begin
        idle_cnt <= 16'd0;
      end else if (tick_stb && (idle_cnt != TIMEOUT_VAL)) begin
        idle_cnt <= idle_cnt + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all derived from registered state only.
  // ---------------------------------------------------------------------------
  assign bus.rd_data  = rd_data_q;
  assign bus.empty    = empty_i;
  assign bus.full     = full_i;
  assign bus.count    = wr_ptr - rd_ptr;
  assign bus.overflow = overflow_q;
  assign bus.timeout  = (idle_cnt == TIMEOUT_VAL) & ~empty_i;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo against a queue model

module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int TO     = 4;

  logic clk = 1'b0;
  logic rst;

  uart_rx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  uart_rx_fifo #(
    .DEPTH(DEPTH),
    .ADDR_W(ADDR_W),
    .TIMEOUT_TICKS(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the FIFO is just a queue of bytes.
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  bit         m_ovf;
  int         m_idle;
  logic [7:0] m_last;

  // Monitor state
  bit         pend = 1'b0;
  logic [7:0] mon_exp;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag);
    chk({tag, ".empty"},    int'(bus.empty),    int'(model_q.size() == 0));
    chk({tag, ".full"},     int'(bus.full),     int'(model_q.size() == DEPTH));
    chk({tag, ".count"},    int'(bus.count),    model_q.size());
    chk({tag, ".overflow"}, int'(bus.overflow), int'(m_ovf));
    chk({tag, ".timeout"},  int'(bus.timeout),  int'((m_idle == TO) && (model_q.size() > 0)));
    chk({tag, ".rd_data"},  int'(bus.rd_data),  int'(m_last));
  endtask

  task automatic model_pop();
    if (model_q.size() > 0) begin
      m_last = model_q.pop_front();
      exp_q.push_back(m_last);
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.rx_done = 1'b1;
    bus.rd_en   = 1'b0;
    bus.clr_ovf = 1'b0;
    bus.tick    = 1'b0;
    repeat (5) step();
    rst = 1'b0;
    model_q.delete();
    m_ovf  = 1'b0;
    m_idle = 0;
    m_last = 8'h00;
  endtask

  // One frame: rx_done low long enough to clear the synchronizers, then high.
  // The write lands on the third edge after the rise; rd_en/clr_ovf are held
  // for exactly that edge when requested.
  task automatic send_byte(input logic [7:0] b, input bit with_pop, input bit with_clr);
    bus.rx_done = 1'b0;
    bus.rx_data = b;
    repeat (3) step();
    bus.rx_done = 1'b1;
    step();
    step();
    bus.rd_en   = with_pop;
    bus.clr_ovf = with_clr;
    step();
    bus.rd_en   = 1'b0;
    bus.clr_ovf = 1'b0;
    if (with_pop) model_pop();
    if (model_q.size() < DEPTH) begin
      model_q.push_back(b);
      m_idle = 0;
      if (with_clr) m_ovf = 1'b0;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic send_tick();
    bus.tick = 1'b1;
    repeat (3) step();
    bus.tick = 1'b0;
    repeat (3) step();
    if (m_idle < TO) m_idle++;
  endtask

  task automatic pop_burst(input int n);
    bus.rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      model_pop();
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic clear_ovf();
    bus.clr_ovf = 1'b1;
    step();
    bus.clr_ovf = 1'b0;
    m_ovf = 1'b0;
  endtask

  // Scoreboard monitor: a pop accepted at an edge is compared on the next
  // falling edge against the oldest expected byte.
  always @(negedge clk) begin
    if (pend) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_data: got 0x%02h expected no pop", bus.rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.rd_data !== mon_exp) begin
          failures++;
          $display("FAIL pop_data: got 0x%02h expected 0x%02h", bus.rd_data, mon_exp);
        end
      end
    end
    pend = bus.rd_en && !bus.empty && !rst;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b1;
    bus.tick    = 1'b0;
    bus.rd_en   = 1'b0;
    bus.clr_ovf = 1'b0;
    rst         = 1'b1;

    // Reset with rx_done held high: no write afterwards.
    do_reset();
    repeat (4) step();
    chk("reset.rd_data_zero", int'(bus.rd_data), 0);
    chk("reset.count_zero",   int'(bus.count),   0);
    check_flags("reset");

    // Single byte with exact write latency.
    bus.rx_data = 8'hA5;
    bus.rx_done = 1'b0;
    repeat (3) step();
    bus.rx_done = 1'b1;
    step();
    chk("single.count_at_N", int'(bus.count), 0);
    step();
    chk("single.empty_at_N1", int'(bus.empty), 1);
    step();
    chk("single.count_at_N2", int'(bus.count), 1);
    chk("single.empty_at_N2", int'(bus.empty), 0);
    model_q.push_back(8'hA5);
    m_idle = 0;
    pop_burst(1);
    chk("single.rd_data", int'(bus.rd_data), 8'hA5);
    check_flags("single");

    // Fill and wrap.
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0, 1'b0);
    chk("fill.full",  int'(bus.full),  1);
    chk("fill.count", int'(bus.count), 16);
    pop_burst(8);
    for (int i = 16; i < 24; i++) send_byte(8'(i), 1'b0, 1'b0);
    pop_burst(16);
    step();
    check_flags("wrap");
    chk("wrap.last", int'(m_last), 8'h17);

    // Overflow, set-beats-clear, clear alone.
    for (int i = 0; i < 16; i++) send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    send_byte(8'hEE, 1'b0, 1'b0);
    chk("ovf.set",   int'(bus.overflow), 1);
    chk("ovf.count", int'(bus.count),    16);
    send_byte(8'h77, 1'b0, 1'b1);
    chk("ovf.set_wins", int'(bus.overflow), 1);
    clear_ovf();
    chk("ovf.cleared", int'(bus.overflow), 0);
    check_flags("ovf");

    // Simultaneous write and pop while full.
    send_byte(8'h55, 1'b1, 1'b0);
    chk("simfull.count", int'(bus.count),    16);
    chk("simfull.ovf",   int'(bus.overflow), 0);
    pop_burst(16);
    step();
    chk("simfull.last", int'(bus.rd_data), 8'h55);
    check_flags("simfull");

    // Simultaneous write and pop while empty: pop ignored.
    send_byte(8'h3C, 1'b1, 1'b0);
    check_flags("simempty");
    pop_burst(1);

    // Timeout.
    do_reset();
    step();
    send_byte(8'h11, 1'b0, 1'b0);
    for (int i = 0; i < TO - 1; i++) send_tick();
    chk("to.before", int'(bus.timeout), 0);
    send_tick();
    chk("to.asserted", int'(bus.timeout), 1);
    send_byte(8'h22, 1'b0, 1'b0);
    chk("to.new_byte_clears", int'(bus.timeout), 0);
    for (int i = 0; i < TO; i++) send_tick();
    chk("to.again", int'(bus.timeout), 1);
    pop_burst(2);
    chk("to.drain_clears", int'(bus.timeout), 0);
    for (int i = 0; i < 10; i++) send_tick();
    chk("to.empty_idle", int'(bus.timeout), 0);
    check_flags("timeout");

    // Randomized traffic against the queue model, including mid-burst reset.
    do_reset();
    step();
    for (int n = 0; n < 400; n++) begin
      int op;
      op = $urandom_range(0, 99);
      if (op < 45)
        send_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
      else if (op < 75)
        pop_burst($urandom_range(1, 4));
      else if (op < 90)
        send_tick();
      else if (op < 97)
        clear_ovf();
      else begin
        step();
        do_reset();
        exp_q.delete();
      end
      if ((n % 8) == 0) check_flags("random");
    end
    pop_burst(DEPTH + 1);
    step();
    check_flags("final");
    step();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
